bus_fifo: RTL and testbench
===========================

BUS_FIFO -- requirements
Module: bus_fifo

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, data bus width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous discard of all stored entries.
REQ-007 SHALL have port in_valid  input  1  upstream word present on in_data.
REQ-008 SHALL have port in_ready  output  1  FIFO accepts a word this cycle.
REQ-009 SHALL have port in_data  input  BUS_WIDTH  upstream data word.
REQ-010 SHALL have port out_valid  output  1  out_data holds the oldest stored word.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the word this cycle.
REQ-012 SHALL have port out_data  output  BUS_WIDTH  oldest stored word.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-014 SHALL perform a push when in_valid && in_ready at a rising clk edge, and a pop when out_valid && out_ready.
REQ-015 SHALL drive in_ready = (level != DEPTH) combinationally; a word is never accepted while full, even with a simultaneous pop.
REQ-016 SHALL drive out_valid = (level != 0); there is no fall-through, so a word pushed into an empty FIFO appears on out_data exactly 1 cycle later.
REQ-017 SHALL deliver words in push order, unmodified, with no loss or duplication.
REQ-018 SHALL keep level unchanged on a simultaneous push and pop; a push alone adds 1 and a pop alone subtracts 1.
REQ-019 SHALL wrap the read and write pointers modulo DEPTH; pointer width is $clog2(DEPTH).
REQ-020 SHALL track occupancy in states EMPTY (level 0), PARTIAL (0 < level < DEPTH) and FULL (level DEPTH).
REQ-021 SHALL use these state transitions: EMPTY->PARTIAL on push; PARTIAL->FULL on a push-only that reaches DEPTH; PARTIAL->EMPTY on a pop-only that reaches 0; FULL->PARTIAL on pop.
REQ-022 SHALL, on flush, set level to 0, set both pointers to 0 and enter EMPTY on the next edge; flush overrides any same-cycle push or pop, and the flushed-cycle input word is dropped.
REQ-023 SHALL hold out_data stable while out_valid && !out_ready.
REQ-024 SHALL hold out_data at its last value while out_valid is 0.

Reset
REQ-025 SHALL, on rst_n low, immediately force level=0, both pointers=0, state EMPTY, out_valid=0 and out_data=0.
REQ-026 SHALL drive in_ready=1 during and after reset.
REQ-027 SHALL not reset storage contents.
REQ-028 SHALL discard all entries when reset asserts mid-transfer, with no partial word visible afterwards.
REQ-029 SHALL accept its first push on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with macro BUS_FIFO_HWM_EN defined, add output port hwm (width $clog2(DEPTH)+1).
REQ-031 SHALL, with BUS_FIFO_HWM_EN defined, have hwm hold the maximum level reached since reset or flush.
REQ-032 SHALL, with BUS_FIFO_HWM_EN defined, reset hwm to 0 and clear it to 0 on flush.
REQ-033 SHALL, with BUS_FIFO_HWM_EN undefined, have no hwm port and no related logic; all other behaviour is identical.

Structure
REQ-034 SHALL place the constant BUS_WIDTH_DFLT=32 and the state enum typedef (EMPTY/PARTIAL/FULL) in shared package bus_fifo_pkg.
REQ-035 SHALL implement storage in sub-module bus_fifo_mem: a DEPTH x BUS_WIDTH register array with one write port and one registered read port.
REQ-036 SHALL keep pointers, state and level in bus_fifo.

Verification
REQ-037 SHALL verify: after reset, push 0xA5A5A5A5 with out_ready=0 -> out_valid=1 and out_data=0xA5A5A5A5 the next cycle, level=1.
REQ-038 SHALL verify: push 4 words (DEPTH=4) with out_ready=0 -> level=4, in_ready=0; a 5th in_valid is not accepted; pop 1 -> in_ready=1.
REQ-039 SHALL verify: at level=2, push and pop in the same cycle for 10 cycles -> level stays 2, output order matches input order across pointer wrap.
REQ-040 SHALL verify: at level=3, assert flush together with in_valid -> next cycle level=0, out_valid=0, and the flushed word is never output.
REQ-041 SHALL verify: drop rst_n mid-stream at level=2 -> out_valid=0 and level=0 immediately without a clock edge, in_ready=1.
REQ-042 SHALL verify, with BUS_FIFO_HWM_EN: fill to 3, drain to 0 -> hwm=3; flush -> hwm=0.

Source files
------------

// File: rtl/bus_fifo_pkg.sv
// bus_fifo_pkg: shared constants and occupancy state type
// for the bus_fifo block.
package bus_fifo_pkg;

  localparam int BUS_WIDTH_DFLT = 32;
  localparam int DEPTH_DFLT     = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_e;

endpackage

// File: rtl/bus_fifo_mem.sv
// bus_fifo_mem: DEPTH x BUS_WIDTH register array, one write
// port, one registered read port with write-data bypass.
module bus_fifo_mem #(
  parameter int BUS_WIDTH = 32,
  parameter int DEPTH     = 4,
  localparam int PW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [PW-1:0]        wr_addr,
  input  logic [BUS_WIDTH-1:0] wr_data,
  input  logic                 rd_en,
  input  logic                 rd_bypass,
  input  logic [PW-1:0]        rd_addr,
  output logic [BUS_WIDTH-1:0] rd_data
);

  logic [BUS_WIDTH-1:0] mem_q [DEPTH];
  logic [BUS_WIDTH-1:0] mem_d [DEPTH];
  logic [BUS_WIDTH-1:0] rd_data_q;
  logic [BUS_WIDTH-1:0] rd_data_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Bypass covers a word written in the same cycle it
  // becomes the head of the queue.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = rd_bypass ? wr_data : mem_q[rd_addr];
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/bus_fifo.sv
// bus_fifo: valid/ready FIFO with registered output.
// Optional high-water mark port under BUS_FIFO_HWM_EN.
module bus_fifo
  import bus_fifo_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DFLT,
  parameter int DEPTH     = DEPTH_DFLT,
  localparam int PW       = $clog2(DEPTH),
  localparam int LW       = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic [LW-1:0]        level
`ifdef BUS_FIFO_HWM_EN
  ,
  output logic [LW-1:0]        hwm
`endif
);

  state_e        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic push, pop;
  logic wr_en, rd_en, rd_bypass;
  logic [PW-1:0] rd_nxt;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign level     = level_q;

  assign push   = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign rd_nxt = rd_ptr_q + PW'(1);

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      state_d  = EMPTY;
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_nxt;
      end
      if (push && !pop) begin
        level_d = level_q + LW'(1);
      end else if (pop && !push) begin
        level_d = level_q - LW'(1);
      end
      unique case (state_q)
        EMPTY: begin
          if (push) state_d = PARTIAL;
        end
        PARTIAL: begin
          if (push && !pop && level_q == LW'(DEPTH - 1))
            state_d = FULL;
          else if (pop && !push && level_q == LW'(1))
            state_d = EMPTY;
        end
        FULL: begin
          if (pop) state_d = PARTIAL;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // The output register reloads only when the head changes:
  // first word into an empty FIFO, or a pop leaving words.
  always_comb begin
    wr_en     = push && !flush;
    rd_bypass = 1'b0;
    rd_en     = 1'b0;
    if (!flush) begin
      rd_bypass = push && (level_q == '0 ||
                  (pop && level_q == LW'(1)));
      rd_en     = rd_bypass || (pop && level_q > LW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  bus_fifo_mem #(
    .BUS_WIDTH (BUS_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_ptr_q),
    .wr_data   (in_data),
    .rd_en     (rd_en),
    .rd_bypass (rd_bypass),
    .rd_addr   (rd_nxt),
    .rd_data   (out_data)
  );

`ifdef BUS_FIFO_HWM_EN
  logic [LW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (flush) begin
      hwm_d = '0;
    end else if (level_d > hwm_q) begin
      hwm_d = level_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_bus_fifo.sv
// tb_bus_fifo: directed + random stimulus for bus_fifo,
// checked against a queue-based reference model.
module tb_bus_fifo;
  localparam int BW = 32;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [BW-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [BW-1:0] out_data;
  logic [LW-1:0] level;
`ifdef BUS_FIFO_HWM_EN
  logic [LW-1:0] hwm;
`endif

  always #5 clk = ~clk;

  bus_fifo #(
    .BUS_WIDTH (BW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
`ifdef BUS_FIFO_HWM_EN
    ,
    .hwm       (hwm)
`endif
  );

  logic [BW-1:0] q[$];
  logic [BW-1:0] last_out = '0;
  int hwm_m = 0;
  int n_chk = 0;
  int n_err = 0;
  int cycn = 0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cycn, obs, exp);
    end
  endtask

  task automatic check_outs();
    check("level", 64'(level), 64'(q.size()));
    check("in_ready", 64'(in_ready),
          64'(q.size() != DEPTH));
    check("out_valid", 64'(out_valid),
          64'(q.size() != 0));
    check("out_data", 64'(out_data),
          64'(q.size() != 0 ? q[0] : last_out));
`ifdef BUS_FIFO_HWM_EN
    check("hwm", 64'(hwm), 64'(hwm_m));
`endif
  endtask

  // Called at a falling edge; leaves at the next one.
  task automatic cyc(input logic v, input logic [BW-1:0] d,
                     input logic r, input logic f);
    logic push, pop;
    check_outs();
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    push = v && (q.size() < DEPTH);
    pop  = r && (q.size() > 0);
    @(posedge clk);
    if (f) begin
      q.delete();
      hwm_m = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
      if (q.size() > hwm_m) hwm_m = q.size();
    end
    if (q.size() != 0) last_out = q[0];
    @(negedge clk);
    cycn++;
  endtask

  task automatic model_reset();
    q.delete();
    last_out = '0;
    hwm_m = 0;
  endtask

  initial begin
    #1;
    check("rst_level", 64'(level), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // first word, no fall-through
    cyc(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
    check("a5_data", 64'(out_data), 64'hA5A5_A5A5);
    check("a5_level", 64'(level), 64'd1);
    // fill, then one refused push, then pop
    for (int i = 0; i < 3; i++)
      cyc(1'b1, $urandom, 1'b0, 1'b0);
    check("full_ready", 64'(in_ready), 64'd0);
    cyc(1'b1, 32'hBAD0_0001, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("pop_ready", 64'(in_ready), 64'd1);
    // full with simultaneous push+pop: push refused
    cyc(1'b1, $urandom, 1'b0, 1'b0);
    cyc(1'b1, 32'hBAD0_0002, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, '0, 1'b1, 1'b0);
    // steady push+pop at level 2 across wrap
    cyc(1'b1, $urandom, 1'b0, 1'b0);
    cyc(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, $urandom, 1'b1, 1'b0);
    check("pp_level", 64'(level), 64'd2);
    // flush at level 3 with a push
    cyc(1'b1, $urandom, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    check("fl_level", 64'(level), 64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    // high-water mark: fill to 3, drain, flush
    for (int i = 0; i < 3; i++)
      cyc(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    // empty push+pop at level 1 exercises bypass
    cyc(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, $urandom, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    // async reset mid-stream at level 2
    cyc(1'b1, $urandom, 1'b0, 1'b0);
    cyc(1'b1, $urandom, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_level", 64'(level), 64'd0);
    check("ar_ready", 64'(in_ready), 64'd1);
    check("ar_data", 64'(out_data), 64'd0);
    model_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // first edge after release accepts a push
    cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    check("post_rst", 64'(out_data), 64'h1234_5678);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 99) < 60), $urandom,
          1'($urandom_range(0, 99) < 50),
          1'($urandom_range(0, 99) < 3));
    end
    cyc(1'b0, '0, 1'b0, 1'b0);
    check_outs();
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
